// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with debounce and single-cycle key events.
// Digit keys shift into an 8-digit packed-BCD number for the display driver.
module keypad_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] number
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_SCANS + 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESS,
        RELEASE
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    r, r_nx;
    logic [1:0]    c, c_nx;
    logic [DW-1:0] deb, deb_nx;
    logic [CW-1:0] cnt;
    logic [3:0]    col_m, col_s;
    logic          sample;
    logic          hit;
    logic [1:0]    hit_c;
    logic [3:0]    code;
    logic [31:0]   num_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_m <= 4'hF;
            col_s <= 4'hF;
        end else begin
            col_m <= col;
            col_s <= col_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (sample)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign sample = (cnt == CW'(SCAN_DIV - 1));
    assign hit    = (col_s != 4'hF);
    assign row    = ~(4'b0001 << r);

    // lowest low column wins when several keys share the strobed row
    always_comb begin
        hit_c = 2'd0;
        priority case (1'b1)
            !col_s[0]: hit_c = 2'd0;
            !col_s[1]: hit_c = 2'd1;
            !col_s[2]: hit_c = 2'd2;
            !col_s[3]: hit_c = 2'd3;
            default:   hit_c = 2'd0;
        endcase
    end

    always_comb begin
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
    end

    always_comb begin
        num_nx = number;
        if (code <= 4'h9)
            num_nx = {number[27:0], code};
        else if (code == 4'hC)
            num_nx = 32'h0;
        else if (code == 4'hD)
            num_nx = {4'h0, number[31:4]};
    end

    always_comb begin
        state_nx = state;
        r_nx     = r;
        c_nx     = c;
        deb_nx   = deb;
        case (state)
            SCAN: begin
                if (sample) begin
                    if (!hit) begin
                        r_nx = r + 2'd1;
                    end else begin
                        c_nx     = hit_c;
                        deb_nx   = DW'(1);
                        state_nx = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (hit && hit_c == c) begin
                        deb_nx = deb + 1'b1;
                        if (deb == DW'(DEB_SCANS - 1))
                            state_nx = PRESS;
                    end else begin
                        deb_nx   = '0;
                        state_nx = SCAN;
                    end
                end
            end
            PRESS: begin
                deb_nx   = '0;
                state_nx = RELEASE;
            end
            RELEASE: begin
                if (sample) begin
                    if (!hit) begin
                        deb_nx = deb + 1'b1;
                        if (deb == DW'(DEB_SCANS - 1)) begin
                            deb_nx   = '0;
                            r_nx     = r + 2'd1;
                            state_nx = SCAN;
                        end
                    end else begin
                        deb_nx = '0;
                    end
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SCAN;
            r     <= 2'd0;
            c     <= 2'd0;
            deb   <= '0;
        end else begin
            state <= state_nx;
            r     <= r_nx;
            c     <= c_nx;
            deb   <= deb_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            number    <= 32'h0;
        end else begin
            key_valid <= (state == PRESS);
            if (state == PRESS) begin
                key_code <= code;
                key_held <= 1'b1;
                number   <= num_nx;
            end else if (state == RELEASE && state_nx == SCAN) begin
                key_held <= 1'b0;
            end
        end
    end

endmodule
